phv_assembler: RTL and testbench

- Sits directly downstream of the parallel sub-parser array in the RMT parser.
- Collects the extracted values from NUM_SUB sub-parser lanes for one packet and places each value into a typed PHV container: 2B, 4B or 6B, eight of each.
- Appends the packet metadata and buffers complete PHVs in a small FIFO.
- Presents them to the first match stage over a valid/ready handshake.

---
 rtl/phv_assembler.sv | 114 +++++++++++
 tb/tb_phv_assembler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phv_assembler.sv
// PHV assembler: places sub-parser lane values into typed 2B/4B/6B containers, appends metadata,
// and buffers complete PHVs in a small FIFO. Optional macro PHV_CONFLICT_CHK_EN adds a sticky collision flag.
module phv_assembler #(
  parameter int NUM_SUB    = 10,
  parameter int VAL_LEN    = 48,
  parameter int META_LEN   = 256,
  parameter int PHV_LEN    = 768 + META_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        axis_clk,
  input  logic                        areset,
  input  logic [NUM_SUB-1:0]          val_valid_in,
  input  logic [NUM_SUB*VAL_LEN-1:0]  val_in,
  input  logic [NUM_SUB*2-1:0]        val_select_in,
  input  logic [NUM_SUB*3-1:0]        val_seq_in,
  input  logic [META_LEN-1:0]         pkt_meta_in,
  output logic                        asm_ready,
  output logic [PHV_LEN-1:0]          phv_out,
  output logic                        phv_valid_out,
  input  logic                        phv_ready_in,
  output logic [31:0]                 drop_cnt,
  output logic                        conflict_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [PHV_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PHV_LEN-1:0] phv_new;
  logic               accept;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // Lanes are visited in ascending order so the highest lane index overwrites earlier ones.
  always_comb begin
    phv_new = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (val_valid_in[i]) begin
        case (val_select_in[i*2 +: 2])
          2'b01:   phv_new[16*int'(val_seq_in[i*3 +: 3]) +: 16]        = val_in[i*VAL_LEN +: 16];
          2'b10:   phv_new[128 + 32*int'(val_seq_in[i*3 +: 3]) +: 32]  = val_in[i*VAL_LEN +: 32];
          2'b11:   phv_new[384 + 48*int'(val_seq_in[i*3 +: 3]) +: 48]  = val_in[i*VAL_LEN +: 48];
          default: ;
        endcase
      end
    end
    phv_new[768 +: META_LEN] = pkt_meta_in;
  end

  assign accept = |val_valid_in;
  assign full   = (count == FULL_CNT);
  assign pop    = phv_valid_out && phv_ready_in;
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr] <= phv_new;
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign phv_valid_out = (count != '0);
  assign asm_ready     = !full;
  assign phv_out       = phv_valid_out ? mem[rd_ptr] : '0;

`ifdef PHV_CONFLICT_CHK_EN
  logic conflict_hit;
  logic conflict_q;

  always_comb begin
    conflict_hit = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) begin
      for (int j = i + 1; j < NUM_SUB; j++) begin
        if (val_valid_in[i] && val_valid_in[j] &&
            (val_select_in[i*2 +: 2] != 2'b00) &&
            (val_select_in[i*2 +: 2] == val_select_in[j*2 +: 2]) &&
            (val_seq_in[i*3 +: 3] == val_seq_in[j*3 +: 3]))
          conflict_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (areset)            conflict_q <= 1'b0;
    else if (conflict_hit) conflict_q <= 1'b1;
  end

  assign conflict_out = conflict_q;
`else
  assign conflict_out = 1'b0;
`endif

endmodule

// File: tb/tb_phv_assembler.sv
// Scoreboard bench for phv_assembler: expected PHVs are queued when driven and
// compared when the DUT hands them downstream.
module tb_phv_assembler;
  localparam int NUM_SUB  = 10;
  localparam int VAL_LEN  = 48;
  localparam int META_LEN = 256;
  localparam int PHV_LEN  = 768 + META_LEN;

  logic                       axis_clk = 1'b0;
  logic                       areset;
  logic [NUM_SUB-1:0]         val_valid_in;
  logic [NUM_SUB*VAL_LEN-1:0] val_in;
  logic [NUM_SUB*2-1:0]       val_select_in;
  logic [NUM_SUB*3-1:0]       val_seq_in;
  logic [META_LEN-1:0]        pkt_meta_in;
  logic                       asm_ready;
  logic [PHV_LEN-1:0]         phv_out;
  logic                       phv_valid_out;
  logic                       phv_ready_in;
  logic [31:0]                drop_cnt;
  logic                       conflict_out;

  phv_assembler dut (
    .axis_clk      (axis_clk),
    .areset        (areset),
    .val_valid_in  (val_valid_in),
    .val_in        (val_in),
    .val_select_in (val_select_in),
    .val_seq_in    (val_seq_in),
    .pkt_meta_in   (pkt_meta_in),
    .asm_ready     (asm_ready),
    .phv_out       (phv_out),
    .phv_valid_out (phv_valid_out),
    .phv_ready_in  (phv_ready_in),
    .drop_cnt      (drop_cnt),
    .conflict_out  (conflict_out)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [767:0]          c;
    logic [META_LEN-1:0]   m;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [31:0]  drop_exp = 0;
  logic [767:0] c;
  logic         conf_exp;

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [1:0] sel, input logic [2:0] seq, input logic [47:0] v);
    val_valid_in[i]        = 1'b1;
    val_select_in[i*2 +: 2] = sel;
    val_seq_in[i*3 +: 3]    = seq;
    val_in[i*VAL_LEN +: VAL_LEN] = v;
  endtask

  // One clock cycle: check outputs against the model, then update the model and advance.
  task automatic tick(input logic [767:0] exp_c);
    int   n;
    logic mpop;
    exp_t e;
    n = sb.size();
    check("valid", phv_valid_out, n != 0);
    check("asm_ready", asm_ready, n < 4);
    check("drop_cnt", drop_cnt, drop_exp);
    mpop = (n != 0) && phv_ready_in;
    if (mpop) begin
      e = sb.pop_front();
      check("phv", phv_out[767:0], e.c);
      check("meta", phv_out[1023:768], e.m);
    end
    if (|val_valid_in) begin
      if (n < 4 || mpop) begin
        e.c = exp_c;
        e.m = pkt_meta_in;
        sb.push_back(e);
      end else begin
        drop_exp++;
      end
    end
    @(posedge axis_clk);
    #1;
    val_valid_in = '0;
  endtask

  initial begin
`ifdef PHV_CONFLICT_CHK_EN
    conf_exp = 1'b1;
`else
    conf_exp = 1'b0;
`endif
    areset        = 1'b1;
    val_valid_in  = '0;
    val_in        = '0;
    val_select_in = '0;
    val_seq_in    = '0;
    pkt_meta_in   = '0;
    phv_ready_in  = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    areset = 1'b0;

    check("rst_valid", phv_valid_out, 1'b0);
    check("rst_phv", phv_out[767:0], '0);
    check("rst_ready", asm_ready, 1'b1);
    check("rst_drop", drop_cnt, '0);
    check("rst_conflict", conflict_out, 1'b0);

    // single packet, two container types
    pkt_meta_in = {32{8'hA5}};
    set_lane(0, 2'b01, 3'd3, 48'h0000_0000_ABCD);
    set_lane(1, 2'b11, 3'd0, 48'h1122_3344_5566);
    c = '0;
    c[48 +: 16]  = 16'hABCD;
    c[384 +: 48] = 48'h1122_3344_5566;
    tick(c);
    tick('0);
    tick('0);

    // back-pressure: five accepts into a four-deep FIFO
    phv_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pkt_meta_in = META_LEN'(k + 16);
      set_lane(0, 2'b01, 3'(k), 48'(k + 1));
      c = '0;
      c[k*16 +: 16] = 16'(k + 1);
      tick(c);
    end
    check("bp_drop", drop_cnt, 32'd1);
    check("bp_ready", asm_ready, 1'b0);

    // full FIFO, pop and push in the same cycle
    phv_ready_in = 1'b1;
    pkt_meta_in  = META_LEN'(99);
    set_lane(0, 2'b10, 3'd0, 48'h0000_CAFE_0001);
    c = '0;
    c[128 +: 32] = 32'hCAFE_0001;
    tick(c);
    check("same_cycle_ready", asm_ready, 1'b0);
    for (int k = 0; k < 5; k++) tick('0);
    check("conflict_before", conflict_out, 1'b0);

    // two lanes hit 4B index 5, higher lane wins
    pkt_meta_in = META_LEN'(7);
    set_lane(2, 2'b10, 3'd5, 48'h0000_1111_1111);
    set_lane(7, 2'b10, 3'd5, 48'h0000_7777_7777);
    c = '0;
    c[288 +: 32] = 32'h7777_7777;
    tick(c);
    check("conflict_t1", conflict_out, conf_exp);
    tick('0);
    check("conflict_sticky", conflict_out, conf_exp);

    // select 00 contributes nothing
    pkt_meta_in = META_LEN'(5);
    set_lane(0, 2'b00, 3'd0, 48'h0000_0000_FFFF);
    tick('0);
    tick('0);

    // reset with three PHVs queued, accept in the reset cycle ignored
    phv_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_lane(3, 2'b11, 3'(k), 48'(k + 40));
      c = '0;
      c[384 + k*48 +: 48] = 48'(k + 40);
      tick(c);
    end
    areset = 1'b1;
    set_lane(4, 2'b01, 3'd1, 48'h0000_0000_BEEF);
    @(posedge axis_clk);
    #1;
    areset       = 1'b0;
    val_valid_in = '0;
    sb.delete();
    drop_exp = 0;
    check("mid_rst_valid", phv_valid_out, 1'b0);
    check("mid_rst_phv", phv_out[767:0], '0);
    check("mid_rst_drop", drop_cnt, '0);
    check("mid_rst_ready", asm_ready, 1'b1);
    check("mid_rst_conflict", conflict_out, 1'b0);

    // post-reset accept appears after one cycle
    phv_ready_in = 1'b1;
    pkt_meta_in  = {64{4'h3}};
    set_lane(9, 2'b01, 3'd7, 48'h0000_0000_1234);
    c = '0;
    c[112 +: 16] = 16'h1234;
    tick(c);
    check("post_rst_valid", phv_valid_out, 1'b1);
    tick('0);
    tick('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
